// File: rtl/serial_pattern_gen_if.sv
// Control and serial-output bundle between a pattern source and serial_pattern_gen.
// The master side requests frames; the slave side (the generator) returns x/busy/done.
interface serial_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH) + 1
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic [3:0]       reps;
    logic             x;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, len, reps,
        input  x, busy, done
    );

    modport slave (
        input  start, abort, pattern, len, reps,
        output x, busy, done
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: shifts a captured pattern out MSB-first, DIV clocks
// per bit, repeated back-to-back reps times, with abort and a one-cycle done pulse.
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1,
    parameter int LW    = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_pattern_gen_if.slave bus
);
    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [LW-1:0] LEN_MAX  = LW'(WIDTH);
    localparam logic [LW-1:0] ONE_L    = LW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [3:0]       reps_q, reps_d;
    logic [DW-1:0]    div_q, div_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LW-1:0]    eff_len_s;
    logic [3:0]       eff_reps_s;

    // Bit at position idx of p; a shift keeps the index width independent of WIDTH.
    function automatic logic pick_bit(input logic [WIDTH-1:0] p, input logic [LW-1:0] idx);
        logic [WIDTH-1:0] shifted;
        shifted = p >> idx;
        return shifted[0];
    endfunction

    assign eff_len_s  = ((bus.len == {LW{1'b0}}) || (bus.len > LEN_MAX)) ? LEN_MAX : bus.len;
    assign eff_reps_s = (bus.reps == 4'd0) ? 4'd1 : bus.reps;

    assign bus.x    = x_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Next-state and next-output logic for the IDLE/SEND sequencer.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        div_d   = div_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                x_d    = 1'b0;
                busy_d = 1'b0;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    pat_d   = bus.pattern;
                    len_d   = eff_len_s;
                    reps_d  = eff_reps_s;
                    idx_d   = eff_len_s - ONE_L;
                    div_d   = {DW{1'b0}};
                    x_d     = pick_bit(bus.pattern, eff_len_s - ONE_L);
                    busy_d  = 1'b1;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    x_d     = 1'b0;
                    busy_d  = 1'b0;
                    div_d   = {DW{1'b0}};
                    idx_d   = {LW{1'b0}};
                end else if (div_q == DIV_LAST) begin
                    div_d = {DW{1'b0}};
                    if (idx_q != {LW{1'b0}}) begin
                        idx_d = idx_q - ONE_L;
                        x_d   = pick_bit(pat_q, idx_q - ONE_L);
                    end else if (reps_q > 4'd1) begin
                        // Next repetition starts on the very next edge: no idle gap.
                        reps_d = reps_q - 4'd1;
                        idx_d  = len_q - ONE_L;
                        x_d    = pick_bit(pat_q, len_q - ONE_L);
                    end else begin
                        state_d = IDLE;
                        x_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, captured frame fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= {WIDTH{1'b0}};
            len_q   <= {LW{1'b0}};
            idx_q   <= {LW{1'b0}};
            reps_q  <= 4'd0;
            div_q   <= {DW{1'b0}};
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            div_q   <= div_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: two instances (DIV=1 and DIV=3) share stimulus and are
// scored every cycle against a sample-queue reference model, plus directed vectors.
module tb_serial_pattern_gen;
    logic       clk;
    logic       rst_n;
    logic       start_s;
    logic       abort_s;
    logic [7:0] pattern_s;
    logic [3:0] len_s;
    logic [3:0] reps_s;

    int checks;
    int failures;

    serial_pattern_gen_if #(.WIDTH(8), .LW(4)) bus1 ();
    serial_pattern_gen_if #(.WIDTH(8), .LW(4)) bus3 ();

    assign bus1.start   = start_s;
    assign bus1.abort   = abort_s;
    assign bus1.pattern = pattern_s;
    assign bus1.len     = len_s;
    assign bus1.reps    = reps_s;
    assign bus3.start   = start_s;
    assign bus3.abort   = abort_s;
    assign bus3.pattern = pattern_s;
    assign bus3.len     = len_s;
    assign bus3.reps    = reps_s;

    serial_pattern_gen #(.WIDTH(8), .DIV(1), .LW(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    serial_pattern_gen #(.WIDTH(8), .DIV(3), .LW(4)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: on acceptance the whole frame is expanded into a list of
    // per-clock x samples; each edge consumes one, and an empty list means done.
    logic       mbits [2][512];
    int         mrd   [2];
    int         mwr   [2];
    bit         mact  [2];
    logic [2:0] mexp  [2];
    int         mdiv  [2];

    typedef struct {
        logic [7:0]  pattern;
        logic [3:0]  len;
        logic [3:0]  reps;
        int          dut;
        int          nbits;
        logic [31:0] xs;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [2:0] dut_out(input int m);
        if (m == 0) return {bus1.x, bus1.busy, bus1.done};
        else        return {bus3.x, bus3.busy, bus3.done};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mact[m] = 1'b0;
            mrd[m]  = 0;
            mwr[m]  = 0;
            mexp[m] = 3'b000;
        end
    endtask

    task automatic model_step(input int m);
        int l;
        int r;
        if (!rst_n) begin
            mact[m] = 1'b0;
            mexp[m] = 3'b000;
        end else if (mact[m]) begin
            if (abort_s) begin
                mact[m] = 1'b0;
                mexp[m] = 3'b000;
            end else if (mrd[m] < mwr[m]) begin
                mexp[m] = {mbits[m][mrd[m]], 2'b10};
                mrd[m]++;
            end else begin
                mact[m] = 1'b0;
                mexp[m] = 3'b001;
            end
        end else begin
            mexp[m] = 3'b000;
            if (start_s && !abort_s) begin
                l = (len_s == 4'd0 || len_s > 4'd8) ? 8 : int'(len_s);
                r = (reps_s == 4'd0) ? 1 : int'(reps_s);
                mwr[m] = 0;
                for (int rr = 0; rr < r; rr++) begin
                    for (int k = l - 1; k >= 0; k--) begin
                        for (int d = 0; d < mdiv[m]; d++) begin
                            mbits[m][mwr[m]] = pattern_s[k];
                            mwr[m]++;
                        end
                    end
                end
                mact[m] = 1'b1;
                mexp[m] = {mbits[m][0], 2'b10};
                mrd[m]  = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("scoreboard_div1", {29'd0, dut_out(0)}, {29'd0, mexp[0]});
        check("scoreboard_div3", {29'd0, dut_out(1)}, {29'd0, mexp[1]});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mact[0] || mact[1]) && n < 1000) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, (mact[0] | mact[1])}, 32'd0);
        tick();
    endtask

    initial begin
        logic [31:0] xv;
        logic [3:0]  hist;
        int          zpos;
        int          n;
        int          d;

        checks   = 0;
        failures = 0;
        mdiv[0]  = 1;
        mdiv[1]  = 3;
        vecs[0]  = '{8'h0D, 4'd4, 4'd1, 0, 4,  32'h0000_000D};
        vecs[1]  = '{8'h02, 4'd2, 4'd2, 1, 12, 32'h0000_0E38};
        vecs[2]  = '{8'hA5, 4'd0, 4'd1, 0, 8,  32'h0000_00A5};
        vecs[3]  = '{8'h01, 4'd1, 4'd3, 0, 3,  32'h0000_0007};

        rst_n     = 1'b0;
        start_s   = 1'b0;
        abort_s   = 1'b0;
        pattern_s = 8'h00;
        len_s     = 4'd0;
        reps_s    = 4'd0;
        model_reset();
        tick();
        tick();
        check("reset_div1", {29'd0, dut_out(0)}, 32'd0);
        check("reset_div3", {29'd0, dut_out(1)}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed frames from the table.
        for (int v = 0; v < 4; v++) begin
            pattern_s = vecs[v].pattern;
            len_s     = vecs[v].len;
            reps_s    = vecs[v].reps;
            start_s   = 1'b1;
            n         = vecs[v].nbits;
            d         = vecs[v].dut;
            xv        = vecs[v].xs;
            tick();
            start_s = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (k > 0) tick();
                check($sformatf("vec%0d_bit%0d", v, k), {29'd0, dut_out(d)}, {29'd0, xv[n - 1 - k], 2'b10});
            end
            tick();
            check($sformatf("vec%0d_done", v), {29'd0, dut_out(d)}, 32'd1);
            tick();
            check($sformatf("vec%0d_after", v), {29'd0, dut_out(d)}, 32'd0);
            wait_idle();
        end

        // start held high and pattern changed mid-frame.
        pattern_s = 8'hB4;
        len_s     = 4'd8;
        reps_s    = 4'd1;
        start_s   = 1'b1;
        xv        = 32'h0000_00B4;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("hold_bit%0d", k), {29'd0, dut_out(0)}, {29'd0, xv[7 - k], 2'b10});
            if (k == 3) pattern_s = 8'h00;
        end
        tick();
        check("hold_done_at_E", {29'd0, dut_out(0)}, 32'd1);
        tick();
        check("hold_restart_E1", {29'd0, dut_out(0)}, 32'd2);
        start_s = 1'b0;
        wait_idle();

        // Abort at bit 2, then abort together with start in IDLE.
        pattern_s = 8'hFF;
        len_s     = 4'd8;
        reps_s    = 4'd1;
        start_s   = 1'b1;
        tick();
        start_s = 1'b0;
        tick();
        tick();
        check("abort_pre", {29'd0, dut_out(0)}, 32'd6);
        abort_s = 1'b1;
        tick();
        check("abort_next_edge", {29'd0, dut_out(0)}, 32'd0);
        abort_s = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("abort_no_done", {31'd0, bus1.done}, 32'd0);
        end
        abort_s = 1'b1;
        start_s = 1'b1;
        tick();
        check("abort_start_idle1", {31'd0, bus1.busy}, 32'd0);
        check("abort_start_idle3", {31'd0, bus3.busy}, 32'd0);
        abort_s = 1'b0;
        start_s = 1'b0;
        wait_idle();

        // Asynchronous reset between edges in the middle of a frame.
        pattern_s = 8'hFF;
        len_s     = 4'd8;
        reps_s    = 4'd2;
        start_s   = 1'b1;
        tick();
        start_s = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_div1", {29'd0, dut_out(0)}, 32'd0);
        check("async_reset_div3", {29'd0, dut_out(1)}, 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {29'd0, dut_out(0)}, 32'd0);

        // Loop x into a 1011 detector; the match completes on bit 5 of 0x2C.
        pattern_s = 8'h2C;
        len_s     = 4'd8;
        reps_s    = 4'd1;
        start_s   = 1'b1;
        hist      = 4'b0000;
        zpos      = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) start_s = 1'b0;
            hist = {hist[2:0], bus1.x};
            if (hist == 4'b1011 && zpos < 0) zpos = k;
        end
        check("detector_z_pos", zpos, 32'd5);
        wait_idle();

        // Randomized traffic scored by the model.
        for (int i = 0; i < 600; i++) begin
            start_s   = ($urandom_range(0, 99) < 30);
            abort_s   = ($urandom_range(0, 99) < 3);
            pattern_s = 8'($urandom);
            len_s     = 4'($urandom_range(0, 15));
            reps_s    = 4'($urandom_range(0, 3));
            tick();
        end
        start_s = 1'b0;
        abort_s = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
